preadder_pipe: RTL

Pipelined, parametrised floating-point pre-adder for the adder datapath. It aligns two unpacked operands to the larger exponent and orders the mantissas so the downstream adder/subtractor always computes great ± small. It is the registered, handshaked successor of the combinational pre-adder, with configurable exponent/mantissa widths, saturating alignment shift and optional sticky-bit collection. It sits between operand unpacking and the mantissa adder.

---
 rtl/preadder_pipe.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/preadder_pipe.sv
// preadder_pipe: two-stage handshaked floating-point pre-adder.
//   Stage 1 aligns the smaller-exponent mantissa to the larger exponent.
//   Stage 2 orders the aligned mantissas so downstream computes great +/- small.
// Optional build macro: PREADDER_STICKY_EN. When defined, the alignment loss
// bit is also folded into bit 0 of the shifted mantissa as a sticky bit.
module preadder_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sign_A,
    input  logic             sign_B,
    input  logic [EXP_W-1:0] exp_A,
    input  logic [EXP_W-1:0] exp_B,
    input  logic [MAN_W-1:0] mantis_A,
    input  logic [MAN_W-1:0] mantis_B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sign_of_great,
    output logic             sign_of_small,
    output logic [EXP_W-1:0] exp,
    output logic [MAN_W-1:0] mantis_great,
    output logic [MAN_W-1:0] mantis_small,
    output logic             loss
);

    // ---------------- handshake ----------------
    logic r_v1, r_v2;
    logic w_ready2, w_accept, w_move;

    assign w_ready2 = !r_v2 || out_ready;
    assign in_ready = !r_v1 || w_ready2;
    assign w_accept = in_valid && in_ready;
    assign w_move   = r_v1 && w_ready2;

    // ---------------- stage 1: alignment ----------------
    logic             w_b_shifted;   // B has the smaller (or equal) exponent
    logic [EXP_W:0]   w_diff;
    logic             w_sat;
    logic [MAN_W-1:0] w_to_shift;
    logic [MAN_W-1:0] w_shifted;
    logic [MAN_W-1:0] w_lost_mask;
    logic             w_loss;
    logic [MAN_W-1:0] w_aligned;

    assign w_b_shifted = (exp_A >= exp_B);
    assign w_diff      = w_b_shifted ? ({1'b0, exp_A} - {1'b0, exp_B})
                                     : ({1'b0, exp_B} - {1'b0, exp_A});
    // Compare in 32 bits so MAN_W larger than the diff range still works.
    assign w_sat       = (32'(w_diff) >= MAN_W);
    assign w_to_shift  = w_b_shifted ? mantis_B : mantis_A;
    assign w_shifted   = w_sat ? '0 : (w_to_shift >> w_diff);
    assign w_lost_mask = w_sat ? '1 : ~({MAN_W{1'b1}} << w_diff);
    assign w_loss      = |(w_to_shift & w_lost_mask);

`ifdef PREADDER_STICKY_EN
    // Sticky bit joins the mantissa so it influences the ordering compare.
    assign w_aligned = w_shifted | {{(MAN_W-1){1'b0}}, w_loss};
`else
    assign w_aligned = w_shifted;
`endif

    logic [EXP_W-1:0] r1_exp;
    logic [MAN_W-1:0] r1_man_a, r1_man_b;
    logic             r1_sign_a, r1_sign_b;
    logic             r1_b_shifted;
    logic             r1_loss;

    // Valid bits for both stages; bubbles collapse via w_ready2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            if (w_accept)    r_v1 <= 1'b1;
            else if (w_move) r_v1 <= 1'b0;
            if (w_move)         r_v2 <= 1'b1;
            else if (out_ready) r_v2 <= 1'b0;
        end
    end

    // Stage 1 data capture on accept; held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_exp       <= '0;
            r1_man_a     <= '0;
            r1_man_b     <= '0;
            r1_sign_a    <= 1'b0;
            r1_sign_b    <= 1'b0;
            r1_b_shifted <= 1'b0;
            r1_loss      <= 1'b0;
        end else if (w_accept) begin
            r1_exp       <= w_b_shifted ? exp_A : exp_B;
            r1_man_a     <= w_b_shifted ? mantis_A : w_aligned;
            r1_man_b     <= w_b_shifted ? w_aligned : mantis_B;
            r1_sign_a    <= sign_A;
            r1_sign_b    <= sign_B;
            r1_b_shifted <= w_b_shifted;
            r1_loss      <= w_loss;
        end
    end

    // ---------------- stage 2: ordering ----------------
    logic [MAN_W-1:0] w_ns_man, w_sh_man;
    logic             w_ns_sign, w_sh_sign;
    logic             w_ns_great;

    assign w_ns_man  = r1_b_shifted ? r1_man_a  : r1_man_b;
    assign w_sh_man  = r1_b_shifted ? r1_man_b  : r1_man_a;
    assign w_ns_sign = r1_b_shifted ? r1_sign_a : r1_sign_b;
    assign w_sh_sign = r1_b_shifted ? r1_sign_b : r1_sign_a;

    // Ties: same sign keeps the non-shifted operand great; opposite signs
    // pick the positive operand so the difference resolves to +0.
    assign w_ns_great = (w_ns_man > w_sh_man) ||
                        ((w_ns_man == w_sh_man) &&
                         ((w_ns_sign == w_sh_sign) || !w_ns_sign));

    logic             r2_sign_g, r2_sign_s;
    logic [EXP_W-1:0] r2_exp;
    logic [MAN_W-1:0] r2_man_g, r2_man_s;
    logic             r2_loss;

    // Stage 2 data capture when stage 1 drains into it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r2_sign_g <= 1'b0;
            r2_sign_s <= 1'b0;
            r2_exp    <= '0;
            r2_man_g  <= '0;
            r2_man_s  <= '0;
            r2_loss   <= 1'b0;
        end else if (w_move) begin
            r2_sign_g <= w_ns_great ? w_ns_sign : w_sh_sign;
            r2_sign_s <= w_ns_great ? w_sh_sign : w_ns_sign;
            r2_exp    <= r1_exp;
            r2_man_g  <= w_ns_great ? w_ns_man : w_sh_man;
            r2_man_s  <= w_ns_great ? w_sh_man : w_ns_man;
            r2_loss   <= r1_loss;
        end
    end

    assign out_valid     = r_v2;
    assign sign_of_great = r2_sign_g;
    assign sign_of_small = r2_sign_s;
    assign exp           = r2_exp;
    assign mantis_great  = r2_man_g;
    assign mantis_small  = r2_man_s;
    assign loss          = r2_loss;

endmodule
